// File: rtl/hdlc_rx_deframer_if.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer_if
// Bundles the serial input and every status/data output of the HDLC receive
// deframer.
//   rx               serial line, one bit per clock
//   rx_flag_detect   pulse: flag 01111110 seen
//   rx_abort_detect  pulse: 0 followed by seven 1s seen
//   rx_abort_signal  pulse: abort while a frame was open
//   rx_valid_frame   level: frame open
//   rx_new_byte      pulse: rx_data holds a new de-stuffed byte
//   rx_data          last data byte, first received bit in bit 0
//   rx_eof           pulse: frame closed by flag
//   rx_frame_error   pulse with rx_eof: bad frame length
//   rx_overflow      level: more than 128 bytes in the current frame
//   rx_frame_size    bytes accepted in current/last frame (max 128)
// master drives rx (line side), slave is the deframer.
// -----------------------------------------------------------------------------
interface hdlc_rx_deframer_if;
    logic       rx;
    logic       rx_flag_detect;
    logic       rx_abort_detect;
    logic       rx_abort_signal;
    logic       rx_valid_frame;
    logic       rx_new_byte;
    logic [7:0] rx_data;
    logic       rx_eof;
    logic       rx_frame_error;
    logic       rx_overflow;
    logic [7:0] rx_frame_size;

    modport master (
        output rx,
        input  rx_flag_detect, rx_abort_detect, rx_abort_signal, rx_valid_frame,
        input  rx_new_byte, rx_data, rx_eof, rx_frame_error, rx_overflow, rx_frame_size
    );

    modport slave (
        input  rx,
        output rx_flag_detect, rx_abort_detect, rx_abort_signal, rx_valid_frame,
        output rx_new_byte, rx_data, rx_eof, rx_frame_error, rx_overflow, rx_frame_size
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// hdlc_rx_deframer
// HDLC receive deframer: detects flags and aborts on the raw bit stream,
// tracks frame open/closed state, removes stuffed zeros and assembles
// LSB-first data bytes, and reports frame length errors and overflow.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  synchronous active-high reset
//   bus    hdlc_rx_deframer_if.slave (rx input, all status/data outputs)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module hdlc_rx_deframer (
    input  logic              clk_i,
    input  logic              rst_i,
    hdlc_rx_deframer_if.slave bus
);
    typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_FRAME = 1'b1} state_t;

    localparam logic [7:0] FLAG_PAT  = 8'h7E;   // oldest bit in [0]
    localparam logic [7:0] ABORT_PAT = 8'hFE;   // 0 then seven 1s
    localparam logic [7:0] MAX_BYTES = 8'd128;
    localparam logic [2:0] SKIP_INIT = 3'd6;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic        flag_hit_q, flag_hit_d;
    logic        abort_hit_q, abort_hit_d;
    logic        valid_q, valid_d;
    logic        flag_det_q, flag_det_d;
    logic        abort_det_q, abort_det_d;
    logic        abort_pend_q, abort_pend_d;
    logic        abort_sig_q, abort_sig_d;
    logic        eof_pend_q, eof_pend_d;
    logic        err_pend_q, err_pend_d;
    logic        eof_q, eof_d;
    logic        ferr_q, ferr_d;
    logic [2:0]  skip_q, skip_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        byte_done_q, byte_done_d;
    logic [7:0]  byte_hold_q, byte_hold_d;
    logic [7:0]  data_q, data_d;
    logic        newbyte_q, newbyte_d;
    logic [7:0]  size_q, size_d;
    logic        ovf_q, ovf_d;

    logic        flag_match_s;
    logic        abort_match_s;
    logic        open_s;
    logic        take_s;
    logic        out_bit_s;

    // Raw history: newest bit enters at [7], the bit leaving [0] is 8 bits old.
    assign sr_d          = {bus.rx, sr_q[7:1]};
    assign flag_match_s  = (sr_q == FLAG_PAT);
    assign abort_match_s = (sr_q == ABORT_PAT);
    assign flag_hit_d    = flag_match_s;
    assign abort_hit_d   = abort_match_s;
    assign out_bit_s     = sr_q[0];

    // The bit leaving the delay line is data only inside a frame, once the
    // opening flag has drained (skip) and while no flag/abort occupies the line.
    assign take_s = (state_q == ST_FRAME) && (skip_q == 3'd0) &&
                    !flag_match_s && !abort_match_s && !flag_hit_q && !abort_hit_q;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and frame-level pulse generation.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flag_det_d   = flag_hit_q;
        abort_det_d  = abort_hit_q;
        abort_pend_d = 1'b0;
        abort_sig_d  = abort_pend_q;
        eof_pend_d   = 1'b0;
        err_pend_d   = 1'b0;
        eof_d        = eof_pend_q;
        ferr_d       = err_pend_q;
        open_s       = 1'b0;
        // An abort drops the frame one cycle after it is detected.
        if (abort_pend_q) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        case (state_q)
            ST_HUNT: begin
                if (flag_hit_q) begin
                    state_d = ST_FRAME;
                    valid_d = 1'b1;
                    open_s  = 1'b1;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_FRAME: begin
                if (flag_hit_q) begin
                    state_d    = ST_HUNT;
                    valid_d    = 1'b0;
                    eof_pend_d = 1'b1;
                    err_pend_d = (bitcnt_q != 3'd0) || (size_q < 8'd2);
                end else if (abort_hit_q) begin
                    state_d      = ST_HUNT;
                    abort_pend_d = 1'b1;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            default: begin
                state_d = ST_HUNT;
                valid_d = 1'b0;
            end
        endcase
    end

    // Zero removal and byte assembly on the bit leaving the delay line.
    always_comb begin
        ones_d      = ones_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        byte_done_d = 1'b0;
        byte_hold_d = byte_hold_q;
        skip_d      = skip_q;
        if (open_s) begin
            ones_d   = 3'd0;
            bitcnt_d = 3'd0;
            skip_d   = SKIP_INIT;
        end else if (skip_q != 3'd0) begin
            skip_d = skip_q - 3'd1;
        end else if (take_s) begin
            if ((ones_q == 3'd5) && !out_bit_s) begin
                ones_d = 3'd0;              // stuffed zero: dropped, not counted
            end else begin
                if (out_bit_s) begin
                    ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
                end else begin
                    ones_d = 3'd0;
                end
                shreg_d  = {out_bit_s, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    byte_done_d = 1'b1;
                    byte_hold_d = {out_bit_s, shreg_q[7:1]};
                end else begin
                    byte_done_d = 1'b0;
                end
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // Byte delivery, frame size and overflow tracking.
    always_comb begin
        data_d    = data_q;
        newbyte_d = 1'b0;
        size_d    = size_q;
        ovf_d     = ovf_q;
        if (open_s) begin
            size_d = 8'd0;
        end else if (byte_done_q) begin
            if (size_q == MAX_BYTES) begin
                ovf_d = 1'b1;
            end else begin
                newbyte_d = 1'b1;
                data_d    = byte_hold_q;
                size_d    = size_q + 8'd1;
            end
        end else begin
            size_d = size_q;
        end
        // Overflow lasts exactly as long as the frame stays open.
        if (valid_q && !valid_d) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q         <= 8'h00;
            flag_hit_q   <= 1'b0;
            abort_hit_q  <= 1'b0;
            valid_q      <= 1'b0;
            flag_det_q   <= 1'b0;
            abort_det_q  <= 1'b0;
            abort_pend_q <= 1'b0;
            abort_sig_q  <= 1'b0;
            eof_pend_q   <= 1'b0;
            err_pend_q   <= 1'b0;
            eof_q        <= 1'b0;
            ferr_q       <= 1'b0;
            skip_q       <= 3'd0;
            ones_q       <= 3'd0;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            byte_done_q  <= 1'b0;
            byte_hold_q  <= 8'h00;
            data_q       <= 8'h00;
            newbyte_q    <= 1'b0;
            size_q       <= 8'd0;
            ovf_q        <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            flag_hit_q   <= flag_hit_d;
            abort_hit_q  <= abort_hit_d;
            valid_q      <= valid_d;
            flag_det_q   <= flag_det_d;
            abort_det_q  <= abort_det_d;
            abort_pend_q <= abort_pend_d;
            abort_sig_q  <= abort_sig_d;
            eof_pend_q   <= eof_pend_d;
            err_pend_q   <= err_pend_d;
            eof_q        <= eof_d;
            ferr_q       <= ferr_d;
            skip_q       <= skip_d;
            ones_q       <= ones_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            byte_done_q  <= byte_done_d;
            byte_hold_q  <= byte_hold_d;
            data_q       <= data_d;
            newbyte_q    <= newbyte_d;
            size_q       <= size_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.rx_flag_detect  = flag_det_q;
    assign bus.rx_abort_detect = abort_det_q;
    assign bus.rx_abort_signal = abort_sig_q;
    assign bus.rx_valid_frame  = valid_q;
    assign bus.rx_new_byte     = newbyte_q;
    assign bus.rx_data         = data_q;
    assign bus.rx_eof          = eof_q;
    assign bus.rx_frame_error  = ferr_q;
    assign bus.rx_overflow     = ovf_q;
    assign bus.rx_frame_size   = size_q;
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_hdlc_rx_deframer
// Drives bit streams built from flags, stuffed bytes and abort patterns into
// hdlc_rx_deframer and compares every output, every cycle, against an
// event-level reference computed from the bit stream, plus direct checks
// of the headline numbers of each scenario.
// Output vector layout: [23] flag [22] abort_det [21] abort_sig [20] valid
// [19] new_byte [18:11] data [10] eof [9] frame_err [8] overflow [7:0] size
// -----------------------------------------------------------------------------
module tb_hdlc_rx_deframer;
    localparam int MAXN = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdlc_rx_deframer_if bus ();
    hdlc_rx_deframer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    bit          tx_q[$];
    int          tx_ones;
    int          n_bits;
    logic [23:0] exp_vec [0:MAXN-1];
    logic [23:0] obs_vec [0:MAXN-1];
    logic [23:0] obs_rst;
    int          dset [0:MAXN-1];
    int          sset [0:MAXN-1];
    int          ob_nb, ob_eof, ob_ferr, ob_adet, ob_asig, ob_flag, ob_ovf, ob_valid;
    logic [7:0]  ob_data[$];
    logic [7:0]  ob_last_size;

    // ---------------- stream construction ----------------
    task automatic tx_raw(bit b);
        tx_q.push_back(b);
    endtask

    task automatic tx_flag();
        tx_raw(1'b0);
        for (int i = 0; i < 6; i++) tx_raw(1'b1);
        tx_raw(1'b0);
        tx_ones = 0;
    endtask

    task automatic tx_abort();
        tx_raw(1'b0);
        for (int i = 0; i < 7; i++) tx_raw(1'b1);
        tx_ones = 0;
    endtask

    // Data bit with zero insertion after five consecutive ones.
    task automatic tx_bit(bit b);
        tx_raw(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                tx_raw(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic tx_byte(logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_bit(v[i]);
    endtask

    task automatic tx_zeros(int n);
        for (int i = 0; i < n; i++) tx_raw(1'b0);
    endtask

    task automatic tx_clear();
        tx_q.delete();
        tx_ones = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit gb(int j);
        if (j < 0 || j >= tx_q.size()) return 1'b0;
        else return tx_q[j];
    endfunction

    function automatic bit is_flag_at(int i);
        bit ok = (gb(i - 7) == 1'b0) && (gb(i) == 1'b0);
        for (int j = i - 6; j <= i - 1; j++) if (gb(j) != 1'b1) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit is_abort_at(int i);
        bit ok = (gb(i - 7) == 1'b0);
        for (int j = i - 6; j <= i; j++) if (gb(j) != 1'b1) ok = 1'b0;
        return ok;
    endfunction

    task automatic set_ev(int t, int pos);
        if (t >= 0 && t < n_bits) exp_vec[t][pos] = 1'b1;
    endtask

    // Frame opened by flag ending at f, ended at c: kind 0 closing flag,
    // 1 abort, 2 still open when the stream ends.
    task automatic close_frame(int f, int c, int kind);
        int ones = 0;
        int nd = 0;
        int ovs = -1;
        int end_t;
        logic [7:0] cur = 8'h00;
        for (int r = f + 1; r <= c - 8 && r < n_bits; r++) begin
            bit b;
            b = gb(r);
            if (ones == 5 && b == 1'b0) begin
                ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                cur[nd % 8] = b;
                nd++;
                if (nd % 8 == 0) begin
                    if (nd / 8 <= 128) begin
                        set_ev(r + 9, 19);
                        if (r + 9 < n_bits) begin
                            dset[r + 9] = int'(cur);
                            sset[r + 9] = nd / 8;
                        end
                    end else if (nd / 8 == 129) begin
                        ovs = r + 9;
                    end
                end
            end
        end
        end_t = (kind == 0) ? c + 2 : ((kind == 1) ? c + 3 : n_bits);
        for (int t = f + 2; t < end_t && t < n_bits; t++) exp_vec[t][20] = 1'b1;
        if (ovs >= 0) for (int t = ovs; t < end_t && t < n_bits; t++) exp_vec[t][8] = 1'b1;
        if (f + 2 < n_bits) sset[f + 2] = 0;
        if (kind == 0) begin
            set_ev(c + 3, 10);
            if ((nd % 8 != 0) || (nd / 8 < 2)) set_ev(c + 3, 9);
        end else if (kind == 1) begin
            set_ev(c + 3, 21);
        end
    endtask

    task automatic build_model();
        bit in_f = 1'b0;
        int fo = 0;
        int dcur = 0;
        int scur = 0;
        for (int t = 0; t < MAXN; t++) begin
            exp_vec[t] = '0;
            dset[t] = -1;
            sset[t] = -1;
        end
        for (int i = 0; i < n_bits; i++) begin
            bit fl, ab;
            fl = is_flag_at(i);
            ab = is_abort_at(i);
            if (fl) set_ev(i + 2, 23);
            if (ab) set_ev(i + 2, 22);
            if (fl) begin
                if (!in_f) begin
                    in_f = 1'b1;
                    fo = i;
                end else begin
                    close_frame(fo, i, 0);
                    in_f = 1'b0;
                end
            end else if (ab && in_f) begin
                close_frame(fo, i, 1);
                in_f = 1'b0;
            end
        end
        if (in_f) close_frame(fo, n_bits + 7, 2);
        for (int t = 0; t < n_bits; t++) begin
            if (dset[t] >= 0) dcur = dset[t];
            if (sset[t] >= 0) scur = sset[t];
            exp_vec[t][18:11] = dcur[7:0];
            exp_vec[t][7:0]   = scur[7:0];
        end
    endtask

    // ---------------- driver / monitor ----------------
    function automatic logic [23:0] pack();
        return {bus.rx_flag_detect, bus.rx_abort_detect, bus.rx_abort_signal,
                bus.rx_valid_frame, bus.rx_new_byte, bus.rx_data, bus.rx_eof,
                bus.rx_frame_error, bus.rx_overflow, bus.rx_frame_size};
    endfunction

    // Reset for two edges, then bit i is sampled by edge i; obs_vec[i] is
    // taken on the falling edge after edge i.
    task automatic run_stream();
        n_bits = tx_q.size();
        build_model();
        rst = 1'b1;
        bus.rx = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs_rst = pack();
        rst = 1'b0;
        bus.rx = tx_q[0];
        ob_nb = 0; ob_eof = 0; ob_ferr = 0; ob_adet = 0;
        ob_asig = 0; ob_flag = 0; ob_ovf = 0; ob_valid = 0;
        ob_data.delete();
        for (int i = 0; i < n_bits; i++) begin
            logic [23:0] v;
            @(posedge clk);
            @(negedge clk);
            v = pack();
            obs_vec[i] = v;
            if (v[19]) begin
                ob_nb++;
                ob_data.push_back(v[18:11]);
            end
            if (v[10]) ob_eof++;
            if (v[9]) ob_ferr++;
            if (v[22]) ob_adet++;
            if (v[21]) ob_asig++;
            if (v[23]) ob_flag++;
            if (v[8]) ob_ovf++;
            if (v[20]) ob_valid++;
            ob_last_size = v[7:0];
            bus.rx = (i + 1 < n_bits) ? tx_q[i + 1] : 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tx_clear();
        tx_zeros(16);
        run_stream();
        n_cmp++;
        if (obs_rst !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected %h", obs_rst, 24'h0);
        end
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
    endtask

    task automatic test_two_bytes();
        tx_clear();
        tx_zeros(3); tx_flag(); tx_byte(8'hA5); tx_byte(8'h3C); tx_flag(); tx_zeros(12);
        run_stream();
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL two_bytes cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_nb !== 2 || ob_data.size() != 2) begin
            n_bad++;
            $display("FAIL two_bytes_count: got %0d expected 2", ob_nb);
        end else begin
            n_cmp++;
            if (ob_data[0] !== 8'hA5 || ob_data[1] !== 8'h3C) begin
                n_bad++;
                $display("FAIL two_bytes_data: got %h %h expected a5 3c", ob_data[0], ob_data[1]);
            end
        end
        n_cmp++;
        if (ob_eof !== 1 || ob_ferr !== 0 || ob_last_size !== 8'd2) begin
            n_bad++;
            $display("FAIL two_bytes_close: got eof %0d err %0d size %0d expected 1 0 2", ob_eof, ob_ferr, ob_last_size);
        end
        // flags end on bits 10 and 34
        n_cmp++;
        if (obs_vec[12][23] !== 1'b1 || obs_vec[36][23] !== 1'b1 || ob_flag !== 2) begin
            n_bad++;
            $display("FAIL two_bytes_flag_timing: got %b %b count %0d expected 1 1 2", obs_vec[12][23], obs_vec[36][23], ob_flag);
        end
    endtask

    task automatic test_stuffing();
        tx_clear();
        tx_flag(); tx_byte(8'hFF); tx_byte(8'h00); tx_flag(); tx_zeros(12);
        run_stream();
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL stuffing cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_data.size() != 2) begin
            n_bad++;
            $display("FAIL stuffing_count: got %0d expected 2", ob_data.size());
        end else if (ob_data[0] !== 8'hFF || ob_data[1] !== 8'h00 || ob_ferr !== 0) begin
            n_bad++;
            $display("FAIL stuffing_data: got %h %h err %0d expected ff 00 0", ob_data[0], ob_data[1], ob_ferr);
        end
    endtask

    task automatic test_abort();
        tx_clear();
        tx_flag(); tx_byte(8'($urandom_range(0, 255))); tx_abort(); tx_zeros(12);
        run_stream();
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL abort cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_adet !== 1 || ob_asig !== 1 || ob_eof !== 0 || ob_ferr !== 0 || obs_vec[n_bits - 1][20] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_summary: got adet %0d asig %0d eof %0d err %0d valid %b expected 1 1 0 0 0",
                     ob_adet, ob_asig, ob_eof, ob_ferr, obs_vec[n_bits - 1][20]);
        end
    endtask

    task automatic test_overflow();
        tx_clear();
        tx_flag();
        for (int b = 0; b < 130; b++) tx_byte(8'($urandom_range(0, 255)));
        tx_flag(); tx_zeros(12);
        run_stream();
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL overflow cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_nb !== 128 || ob_last_size !== 8'd128 || ob_eof !== 1 || ob_ferr !== 0 || ob_ovf == 0) begin
            n_bad++;
            $display("FAIL overflow_summary: got nb %0d size %0d eof %0d err %0d ovf_cycles %0d expected 128 128 1 0 >0",
                     ob_nb, ob_last_size, ob_eof, ob_ferr, ob_ovf);
        end
    endtask

    task automatic test_frame_error();
        tx_clear();
        tx_flag(); tx_byte(8'($urandom_range(0, 255))); tx_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) tx_bit(1'($urandom_range(0, 1)));
        tx_flag(); tx_zeros(12);
        run_stream();
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL frame_error cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_eof !== 1 || ob_ferr !== 1 || ob_nb !== 2) begin
            n_bad++;
            $display("FAIL frame_error_summary: got eof %0d err %0d nb %0d expected 1 1 2", ob_eof, ob_ferr, ob_nb);
        end
    endtask

    task automatic test_random_frames();
        for (int rep = 0; rep < 4; rep++) begin
            tx_clear();
            tx_zeros(int'($urandom_range(0, 4)));
            for (int fr = 0; fr < 4; fr++) begin
                int nb;
                tx_flag();
                nb = int'($urandom_range(1, 5));
                for (int b = 0; b < nb; b++) tx_byte(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 7)); k++) tx_bit(1'($urandom_range(0, 1)));
                end
                if ($urandom_range(0, 4) == 0) tx_abort();
                else tx_flag();
                tx_zeros(int'($urandom_range(0, 3)));
            end
            tx_zeros(12);
            run_stream();
            for (int i = 0; i < n_bits; i++) begin
                n_cmp++;
                if (obs_vec[i] !== exp_vec[i]) begin
                    n_bad++;
                    $display("FAIL random_frames rep %0d cycle %0d: got %h expected %h", rep, i, obs_vec[i], exp_vec[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        tx_clear();
        tx_flag(); tx_byte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) tx_bit(1'($urandom_range(0, 1)));
        run_stream();
        n_cmp++;
        if (obs_vec[n_bits - 1][20] !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_open: got valid %b expected 1", obs_vec[n_bits - 1][20]);
        end
        // reset lands while the frame is open, then an abort pattern follows
        tx_clear();
        tx_abort(); tx_zeros(12);
        run_stream();
        n_cmp++;
        if (obs_rst !== 24'h0) begin
            n_bad++;
            $display("FAIL midframe_reset_values: got %h expected %h", obs_rst, 24'h0);
        end
        for (int i = 0; i < n_bits; i++) begin
            n_cmp++;
            if (obs_vec[i] !== exp_vec[i]) begin
                n_bad++;
                $display("FAIL midframe_abort cycle %0d: got %h expected %h", i, obs_vec[i], exp_vec[i]);
            end
        end
        n_cmp++;
        if (ob_adet !== 1 || ob_asig !== 0 || ob_eof !== 0 || ob_valid !== 0) begin
            n_bad++;
            $display("FAIL midframe_summary: got adet %0d asig %0d eof %0d valid_cycles %0d expected 1 0 0 0",
                     ob_adet, ob_asig, ob_eof, ob_valid);
        end
    endtask

    initial begin
        bus.rx = 1'b0;
        test_reset();
        test_two_bytes();
        test_stuffing();
        test_abort();
        test_overflow();
        test_frame_error();
        test_random_frames();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
